// File: rtl/seven_segment_scan_controller_if.sv
// Bus between the value source / display pins and the scan controller.
interface seven_segment_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    update_pending;
  logic                    frame_done;

  modport master (
    output enable, load, value,
    input  bcd_out, digit_en, update_pending, frame_done
  );

  modport slave (
    input  enable, load, value,
    output bcd_out, digit_en, update_pending, frame_done
  );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed 7-segment scan controller: one shared decoder, one-hot digit
// enables with blanking gaps, double-buffered value committed at frame start.
module seven_segment_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  seven_segment_scan_controller_if.slave bus
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    frame_start, wrap;

  logic [4*NUM_DIGITS-1:0] disp_q, disp_nxt;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_nxt;
  logic                    upd_q, upd_nxt;
  logic [3:0]              bcd_q, bcd_nxt;
  logic [NUM_DIGITS-1:0]   den_q, den_nxt;
  logic                    fd_q, fd_nxt;

  // State, digit index and slot counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: the counter runs through BLANK then SHOW within one slot and
  // restarts at 0 on every new slot; disabling forces IDLE from anywhere.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    frame_start = 1'b0;
    wrap        = 1'b0;
    if (!bus.enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = BLANK;
          idx_nxt     = '0;
          cnt_nxt     = '0;
          frame_start = 1'b1;
        end
        BLANK: begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(BLANK_CYCLES - 1))
            state_nxt = SHOW;
        end
        SHOW: begin
          if (cnt == CW'(REFRESH_DIV - 1)) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            if (idx == IW'(NUM_DIGITS - 1)) begin
              idx_nxt     = '0;
              wrap        = 1'b1;
              frame_start = 1'b1;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output/buffer next values, derived from the next state so the registered
  // outputs line up with the state they describe. A load on the commit edge
  // loses to the already-pending value for this frame but stays pending.
  always_comb begin
    disp_nxt = (frame_start && upd_q) ? pend_q : disp_q;
    pend_nxt = bus.load ? bus.value : pend_q;
    upd_nxt  = bus.load ? 1'b1 : (frame_start ? 1'b0 : upd_q);
    bcd_nxt  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (idx_nxt == IW'(i))
        bcd_nxt = disp_nxt[4*i +: 4];
    den_nxt  = (state_nxt == SHOW) ? (NUM_DIGITS'(1) << idx_nxt) : '0;
    fd_nxt   = wrap;
  end

  // Registered outputs and value buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q <= '0;
      pend_q <= '0;
      upd_q  <= 1'b0;
      bcd_q  <= '0;
      den_q  <= '0;
      fd_q   <= 1'b0;
    end else begin
      disp_q <= disp_nxt;
      pend_q <= pend_nxt;
      upd_q  <= upd_nxt;
      bcd_q  <= bcd_nxt;
      den_q  <= den_nxt;
      fd_q   <= fd_nxt;
    end
  end

  assign bus.bcd_out        = bcd_q;
  assign bus.digit_en       = den_q;
  assign bus.update_pending = upd_q;
  assign bus.frame_done     = fd_q;
endmodule
